// File: rtl/product_accumulator_pkg.sv
// Shared constants and helpers for the product accumulator slice.
// MUL_W is the multiplier stage output width.
package product_accumulator_pkg;

  localparam int MUL_W     = 32;
  localparam int LEN_DEF   = 4;
  localparam int ACC_W_DEF = 40;
  localparam int DEPTH_DEF = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// First-word fall-through result queue with a registered head.
// The head keeps the last popped value once the queue drains.
module result_fifo
  import product_accumulator_pkg::*;
#(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         drop,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_nxt;
  logic [AW:0]   rd_nxt;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic [W-1:0]  head_nxt;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid   = !empty;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign wr_nxt  = wr_ptr + (AW+1)'(push_ok);
  assign rd_nxt  = rd_ptr + (AW+1)'(pop_ok);

  // Bypass covers a push landing in the slot that becomes the head.
  assign head_nxt =
    (push_ok && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) ?
    din : mem[rd_nxt[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (wr_nxt != rd_nxt) dout <= head_nxt;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums every LEN multiplier products into one result and queues it.
// Input cannot stall: results arriving at a full queue are dropped.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int IN_W  = MUL_W,
  parameter int LEN   = LEN_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW   = clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_payload,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [ACC_W-1:0] o_payload,
  output logic [CW-1:0]    o_count,
  output logic             o_overflow
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] sum;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_base;
  logic             last;
  logic             push;
  logic             full;
  logic             drop;

  // Flush restarts the vector; a same-cycle product becomes element 1.
  always_comb begin
    acc_base = i_flush ? '0 : acc;
    cnt_base = i_flush ? '0 : cnt;
    sum      = acc_base + ACC_W'(i_payload);
    last     = (cnt_base == CW'(LEN - 1));
    push     = i_valid && last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (i_valid && last) begin
        acc <= '0;
        cnt <= '0;
      end else if (i_valid) begin
        acc <= sum;
        cnt <= cnt_base + CW'(1);
      end else begin
        acc <= acc_base;
        cnt <= cnt_base;
      end
      if (drop) o_overflow <= 1'b1;
    end
  end

  assign o_count = cnt;

  result_fifo #(
    .W     (ACC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (sum),
    .full  (full),
    .drop  (drop),
    .pop   (o_ready),
    .valid (o_valid),
    .dout  (o_payload)
  );

endmodule
